// File: rtl/card_deal_arbiter.sv
// Round-robin arbiter sharing one card source between player and dealer requesters.
// Define DEAL_SKIP_EN to hold the source enable for SKIP_N extra advances per deal.
module card_deal_arbiter #(
  parameter int unsigned MAX_CARDS = 10,
  parameter int unsigned SKIP_N    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       round_start,
  input  logic [1:0] req,
  input  logic [1:0] card_ack,
  input  logic [3:0] src_card,
  output logic       src_enable,
  output logic [3:0] card_out,
  output logic [1:0] card_valid,
  output logic       busy,
  output logic [3:0] cards_dealt,
  output logic       limit_hit
);

  if (MAX_CARDS < 1 || MAX_CARDS > 15 || SKIP_N < 1 || SKIP_N > 7) begin : g_param_check
    $error("card_deal_arbiter: MAX_CARDS must be 1..15 and SKIP_N 1..7");
  end

  typedef enum logic [2:0] {StIdle, StPulse, StSkip, StCapture, StDeliver} state_e;

  localparam logic [3:0] MaxCards = 4'(MAX_CARDS);

  state_e     state_q, state_d;
  logic       grant_q, grant_d;     // 0 player, 1 dealer
  logic       last_q, last_d;
  logic       pending_q, pending_d; // round_start seen mid-deal
  logic [3:0] card_q, card_d;
  logic [3:0] dealt_q, dealt_d;

`ifdef DEAL_SKIP_EN
  localparam logic [2:0] SkipLast = 3'(SKIP_N - 1);
  logic [2:0] skip_q, skip_d;
`endif

  assign limit_hit   = (dealt_q == MaxCards);
  assign busy        = (state_q != StIdle);
  assign card_out    = card_q;
  assign cards_dealt = dealt_q;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    pending_d  = pending_q;
    card_d     = card_q;
    dealt_d    = dealt_q;
    src_enable = 1'b0;
    card_valid = 2'b00;
`ifdef DEAL_SKIP_EN
    skip_d     = skip_q;
`endif
    case (state_q)
      StIdle: begin
        if (round_start || pending_q) begin
          dealt_d   = 4'd0;
          last_d    = 1'b1;
          pending_d = 1'b0;
        end else if (req != 2'b00 && !limit_hit) begin
          grant_d = (req == 2'b11) ? ~last_q : req[1];
          state_d = StPulse;
        end
      end
      StPulse: begin
        src_enable = 1'b1;
`ifdef DEAL_SKIP_EN
        skip_d  = 3'd0;
        state_d = StSkip;
`else
        state_d = StCapture;
`endif
      end
`ifdef DEAL_SKIP_EN
      StSkip: begin
        src_enable = 1'b1;
        if (skip_q == SkipLast) begin
          state_d = StCapture;
        end else begin
          skip_d = skip_q + 3'd1;
        end
      end
`endif
      StCapture: begin
        // Source output reflects the last advance by now.
        card_d  = src_card;
        state_d = StDeliver;
      end
      StDeliver: begin
        card_valid = grant_q ? 2'b10 : 2'b01;
        if (card_ack[grant_q]) begin
          if (dealt_q != MaxCards) begin
            dealt_d = dealt_q + 4'd1;
          end
          last_d  = grant_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_q != StIdle && round_start) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      pending_q <= 1'b0;
      card_q    <= 4'd0;
      dealt_q   <= 4'd0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      pending_q <= pending_d;
      card_q    <= card_d;
      dealt_q   <= dealt_d;
    end
  end

`ifdef DEAL_SKIP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skip_q <= 3'd0;
    end else begin
      skip_q <= skip_d;
    end
  end
`endif

endmodule

// File: tb/tb_card_deal_arbiter.sv
// Randomized bench for card_deal_arbiter against a deal-age reference model.
module tb_card_deal_arbiter;

  localparam int MAX = 3;
  localparam int SKIPN = 3;
`ifdef DEAL_SKIP_EN
  localparam int SKIP = SKIPN;
`else
  localparam int SKIP = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       round_start;
  logic [1:0] req;
  logic [1:0] card_ack;
  logic [3:0] src_card;
  logic       src_enable;
  logic [3:0] card_out;
  logic [1:0] card_valid;
  logic       busy;
  logic [3:0] cards_dealt;
  logic       limit_hit;

  int n_cmp = 0;
  int n_err = 0;

  // Model: phase -1 idle, otherwise clocks since the grant was taken.
  int m_phase, m_granted, m_last, m_count, m_card;
  bit m_pending;

  card_deal_arbiter #(.MAX_CARDS(MAX), .SKIP_N(SKIPN)) dut (
    .clk        (clk),
    .reset      (reset),
    .round_start(round_start),
    .req        (req),
    .card_ack   (card_ack),
    .src_card   (src_card),
    .src_enable (src_enable),
    .card_out   (card_out),
    .card_valid (card_valid),
    .busy       (busy),
    .cards_dealt(cards_dealt),
    .limit_hit  (limit_hit)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (got running, want finished)");
    $fatal(1);
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, want %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = -1; m_granted = 0; m_last = 1; m_count = 0; m_card = 0; m_pending = 0;
  endtask

  task automatic check_outputs();
    check("src_enable", src_enable, (m_phase >= 0 && m_phase <= SKIP) ? 1 : 0);
    check("card_valid", card_valid, (m_phase >= SKIP + 2) ? (m_granted ? 2 : 1) : 0);
    check("card_out", card_out, m_card);
    check("busy", busy, (m_phase >= 0) ? 1 : 0);
    check("cards_dealt", cards_dealt, m_count);
    check("limit_hit", limit_hit, (m_count == MAX) ? 1 : 0);
  endtask

  // Advance the model across the next rising edge using the currently driven inputs.
  task automatic model_step();
    if (m_phase < 0) begin
      if (round_start || m_pending) begin
        m_count = 0; m_last = 1; m_pending = 0;
      end else if (req != 0 && m_count < MAX) begin
        m_granted = (req == 2'b11) ? 1 - m_last : (req == 2'b10 ? 1 : 0);
        m_phase = 0;
      end
    end else begin
      if (round_start) m_pending = 1;
      if (m_phase == SKIP + 1) begin
        m_card = int'(src_card);
        m_phase++;
      end else if (m_phase >= SKIP + 2) begin
        if (card_ack[m_granted]) begin
          if (m_count < MAX) m_count++;
          m_last = m_granted;
          m_phase = -1;
        end
      end else begin
        m_phase++;
      end
    end
  endtask

  task automatic cycle(input logic [1:0] r, input logic [1:0] a, input logic rs,
                       input logic [3:0] s);
    req = r; card_ack = a; round_start = rs; src_card = s;
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic async_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    check_outputs();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; round_start = 1'b0; req = 2'b00; card_ack = 2'b00; src_card = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 1'b1;

    // Single player deal with src_card=7, then immediate ack.
    repeat (SKIP + 3) cycle(2'b01, 2'b00, 1'b0, 4'd7);
    cycle(2'b01, 2'b01, 1'b0, 4'd7);
    cycle(2'b00, 2'b00, 1'b0, 4'd7);

    // Both requesting with immediate acks alternates grants.
    cycle(2'b00, 2'b00, 1'b1, 4'd2);
    for (int i = 0; i < 4 * (SKIP + 4); i++) cycle(2'b11, 2'b11, 1'b0, 4'(1 + i % 11));

    // Limit reached, then cleared by round_start.
    for (int i = 0; i < 24; i++) cycle(2'b01, 2'b01, 1'b0, 4'd4);
    cycle(2'b01, 2'b01, 1'b1, 4'd4);

    // Ack withheld with toggling source; wrong-bit ack ignored.
    for (int i = 0; i < SKIP + 8; i++) cycle(2'b01, 2'b00, 1'b0, 4'(i[0] ? 9 : 3));
    cycle(2'b00, 2'b10, 1'b0, 4'd5);
    cycle(2'b00, 2'b10, 1'b0, 4'd6);
    cycle(2'b00, 2'b01, 1'b0, 4'd6);

    // round_start mid-deal is deferred until the card is counted.
    cycle(2'b10, 2'b00, 1'b0, 4'd8);
    cycle(2'b00, 2'b00, 1'b1, 4'd8);
    for (int i = 0; i < SKIP + 4; i++) cycle(2'b00, 2'b10, 1'b0, 4'd8);

    // Async reset while pulsing.
    cycle(2'b01, 2'b00, 1'b0, 4'd1);
    if (m_phase == 0) async_reset();
    else check("pulse_reached", 32'(m_phase), 0);

    for (int i = 0; i < 3000; i++) begin
      cycle(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 15) == 0), 4'($urandom_range(1, 11)));
      if (m_phase == 0 && $urandom_range(0, 19) == 0) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
